// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets (Addr[4:2]),
// source indices and the priority helper used to build the CAUSE register.
package irq_controller_pkg;

  localparam int unsigned NUM_IRQ = 6;

  localparam logic [2:0] IRQ_REG_ENABLE  = 3'd0;
  localparam logic [2:0] IRQ_REG_MASK    = 3'd1;
  localparam logic [2:0] IRQ_REG_PENDING = 3'd2;
  localparam logic [2:0] IRQ_REG_MODE    = 3'd3;
  localparam logic [2:0] IRQ_REG_CAUSE   = 3'd4;

  localparam int unsigned IRQ_SRC_TIMER0 = 0;
  localparam int unsigned IRQ_SRC_TIMER1 = 1;
  localparam int unsigned IRQ_SRC_EXT    = 2;

  // Index of the lowest-numbered set bit; 0 when no bit is set.
  function automatic logic [2:0] irq_lowest_idx(input logic [NUM_IRQ-1:0] vec);
    logic [2:0] idx;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Per-source input synchronizer with edge detector.
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous active-high reset
//   irq_i   raw asynchronous interrupt line
//   s_o     synchronized level (last stage of the chain)
//   rise_o  s_o high while the one-cycle-delayed copy is low
module irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  output logic s_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
      // Runs in every mode so a mode switch never manufactures an edge.
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = s_o & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller feeding CPU HWInt[7:2].
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   Addr        word address; only Addr[4:2] decoded
//   WData, WE   write data and single-cycle write strobe
//   RData       combinational read data for Addr
//   IRQ_In      raw source lines (0 Timer0, 1 Timer1, 2 external, 5:3 spare)
//   HWInt       registered request vector, bit i -> CPU HWInt[i+2]
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [NUM_IRQ-1:0] RESET_MASK  = 6'b000000,
  parameter logic [NUM_IRQ-1:0] RESET_MODE  = 6'b000111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:2]        Addr,
  input  logic [31:0]        WData,
  input  logic               WE,
  output logic [31:0]        RData,
  input  logic [NUM_IRQ-1:0] IRQ_In,
  output logic [NUM_IRQ-1:0] HWInt
);

  logic [NUM_IRQ-1:0] s, rise;
  logic [2:0]         sel;
  logic               gie_q, gie_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] hwint_q, hwint_d;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] active;
  logic               unused_bits;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_i (clk),
      .rst_i (reset),
      .irq_i (IRQ_In[i]),
      .s_o   (s[i]),
      .rise_o(rise[i])
    );
  end

  assign sel         = Addr[4:2];
  assign active      = pend_q & mask_q;
  assign unused_bits = ^{Addr[31:5], WData[31:6]};

  always_comb begin
    gie_d  = gie_q;
    mask_d = mask_q;
    mode_d = mode_q;
    w1c    = '0;
    if (WE) begin
      case (sel)
        IRQ_REG_ENABLE:  gie_d  = WData[0];
        IRQ_REG_MASK:    mask_d = WData[NUM_IRQ-1:0];
        IRQ_REG_PENDING: w1c    = WData[NUM_IRQ-1:0];
        IRQ_REG_MODE:    mode_d = WData[NUM_IRQ-1:0];
        default:         ;
      endcase
    end
    // Edge sources: a set event beats a same-cycle clear. Level sources follow s.
    for (int i = 0; i < NUM_IRQ; i++) begin
      pend_d[i] = mode_q[i] ? (rise[i] | (pend_q[i] & ~w1c[i])) : s[i];
    end
    hwint_d = gie_q ? active : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gie_q   <= 1'b0;
      mask_q  <= RESET_MASK;
      mode_q  <= RESET_MODE;
      pend_q  <= '0;
      hwint_q <= '0;
    end else begin
      gie_q   <= gie_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      hwint_q <= hwint_d;
    end
  end

  assign HWInt = hwint_q;

  always_comb begin
    RData = '0;
    case (sel)
      IRQ_REG_ENABLE:  RData = {31'b0, gie_q};
      IRQ_REG_MASK:    RData = {26'b0, mask_q};
      IRQ_REG_PENDING: RData = {26'b0, pend_q};
      IRQ_REG_MODE:    RData = {26'b0, mode_q};
      IRQ_REG_CAUSE:   RData = (|active) ? {1'b1, 28'b0, irq_lowest_idx(active)} : '0;
      default:         RData = '0;
    endcase
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller between the device-side interrupt sources and the CPU's HWInt[7:2] input.
- Synchronizes six raw interrupt lines and latches them per source as edge- or level-triggered.
- Applies a per-source mask and a global enable, and exposes status and priority-cause registers.
- Occupies one device window behind the SouthBridge, which decodes the base address and drives this block's Addr/WData/WE.

Parameters:
- SYNC_STAGES, 2: synchronizer flop depth per source; legal range 2..3.
- RESET_MASK, 6'b000000: MASK register value after reset.
- RESET_MODE, 6'b000111: MODE register value after reset (1 = edge, 0 = level).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- Addr  input  [31:2]  word address; only Addr[4:2] is decoded.
- WData  input  32  write data.
- WE  input  1  write strobe, single-cycle, already qualified by the SouthBridge decode.
- RData  output  32  read data, combinational from Addr.
- IRQ_In  input  6  raw source lines; bit0 = Timer0, bit1 = Timer1, bit2 = external, bits 5:3 spare.
- HWInt  output  6  registered request vector to the CPU; bit i maps to CPU HWInt[i+2].

Behaviour:
- Reset and clock domain: one clock; reset is asynchronous and active-high.
- Reset values:
  - Sync chains, pending and HWInt all cleared to 0.
  - ENABLE = 0.
  - MASK = RESET_MASK; MODE = RESET_MODE.
- Register map (Addr[4:2]):
  - 0 ENABLE: RW, bit0 = GIE, other bits read 0.
  - 1 MASK: RW [5:0].
  - 2 PENDING: read [5:0]; write-1-to-clear.
  - 3 MODE: RW [5:0].
  - 4 CAUSE: RO; bit31 = valid, [2:0] = index of lowest-numbered set bit of (PENDING & MASK); reads 0 when none.
  - 5..7: read 0; writes ignored.
- Register writes take effect at the clock edge where WE=1. A read in the same cycle returns the old value.
- Synchronizer: each IRQ_In bit passes through SYNC_STAGES flops, giving s[i]. A prev[i] flop holds s[i] delayed one cycle.
- Edge mode (MODE[i]=1):
  - s[i]=1 and prev[i]=0 sets pending[i].
  - W1C write of 1 clears pending[i].
  - A set event and a clear in the same cycle: set wins, pending stays 1.
  - Holding the line high does not re-set pending after it is cleared.
- Level mode (MODE[i]=0):
  - pending[i] <= s[i] every cycle.
  - W1C has no effect.
- Mode switch:
  - Level→edge: pending[i] keeps its current value.
  - Edge→level: pending[i] tracks s[i] from the next edge.
  - prev keeps updating in both modes, so no spurious edge appears on a switch.
- Output: HWInt <= GIE ? (pending & MASK) : 6'b0, registered.
- Latency, SYNC_STAGES=2:
  - Rising line first sampled at edge k.
  - pending set at edge k+2.
  - HWInt high after edge k+3.
- Mask, GIE or W1C changes reach HWInt one edge after the register update.
- Reset asserted mid-operation clears state immediately, regardless of clk. On deassertion, a line held high is seen as an edge after the sync chain fills, because prev resets to 0.
- RData is undefined-free: always a defined value, 0 on unused bits.

Decomposition:
- Shared package holds:
  - register offset constants: IRQ_REG_ENABLE = 3'd0, MASK = 3'd1, PENDING = 3'd2, MODE = 3'd3, CAUSE = 3'd4;
  - source index constants: IRQ_SRC_TIMER0 = 0, TIMER1 = 1, EXT = 2;
  - NUM_IRQ = 6.
- One sub-module, irq_sync:
  - per-source SYNC_STAGES synchronizer plus prev flop;
  - outputs level s and rise pulse;
  - instantiated 6 times via generate.
- The top module holds the register file, the pending logic, the priority encoder and RData muxing.

Test Plan:
- Reset, then read all registers → ENABLE=0, MASK=0, PENDING=0, MODE=0x07, CAUSE=0, HWInt=0; Addr[4:2]=6 reads 0.
- Write MASK=0x01 and ENABLE=1, pulse IRQ_In[0] high for 1 cycle sampled at edge k → PENDING=0x01 after edge k+2; HWInt=0x01 after edge k+3; CAUSE=0x80000000.
- Write PENDING=0x01 in the same cycle a new rising edge on IRQ_In[0] reaches the edge detector → PENDING stays 0x01. A W1C with no edge → PENDING=0 and HWInt=0 one edge later.
- Write MODE=0x00, hold IRQ_In[2] high with MASK=0x04 → PENDING=0x04 and HWInt=0x04. W1C 0x04 leaves PENDING=0x04. Drop IRQ_In[2] → PENDING=0 after 3 edges.
- Set MASK=0x3F and pend sources 1 and 4 → CAUSE=0x80000001. Clear ENABLE → HWInt=0 next edge while PENDING stays 0x12.
- Pend source 0, assert reset asynchronously between clock edges → HWInt and PENDING go to 0 without waiting for clk; MASK returns to RESET_MASK.
